// File: rtl/baccarat_ctrl.sv
// Baccarat round sequencer.
// Steps through the deal one key press at a time, strobing each card register
// in deal order, then applies the natural, player-draw and banker-draw rules
// before settling in DONE with the win lights.
module baccarat_ctrl (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic       round_done
);

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] DP1   = 4'd1;
    localparam logic [3:0] DD1   = 4'd2;
    localparam logic [3:0] DP2   = 4'd3;
    localparam logic [3:0] DD2   = 4'd4;
    localparam logic [3:0] EVAL1 = 4'd5;
    localparam logic [3:0] DP3   = 4'd6;
    localparam logic [3:0] EVAL2 = 4'd7;
    localparam logic [3:0] DD3   = 4'd8;
    localparam logic [3:0] DONE  = 4'd9;

    logic [3:0] state;
    logic [3:0] next_state;
    logic [3:0] p3v;
    logic       is_natural;
    logic       banker_draws;

    // Face cards and tens count as zero toward the banker decision.
    always_comb begin
        p3v = 4'd0;
        if (pcard3 >= 4'd1 && pcard3 <= 4'd9) begin
            p3v = pcard3;
        end
    end

    // Banker tableau once the player has taken a third card.
    always_comb begin
        banker_draws = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: banker_draws = 1'b1;
            4'd3:             banker_draws = (p3v != 4'd8);
            4'd4:             banker_draws = (p3v >= 4'd2) && (p3v <= 4'd7);
            4'd5:             banker_draws = (p3v >= 4'd4) && (p3v <= 4'd7);
            4'd6:             banker_draws = (p3v >= 4'd6) && (p3v <= 4'd7);
            default:          banker_draws = 1'b0;
        endcase
    end

    // Next-state logic: fixed deal order, then the two decision points.
    always_comb begin
        next_state = state;
        is_natural = (pscore >= 4'd8) || (dscore >= 4'd8);
        case (state)
            IDLE:  next_state = DP1;
            DP1:   next_state = DD1;
            DD1:   next_state = DP2;
            DP2:   next_state = DD2;
            DD2:   next_state = EVAL1;
            EVAL1: begin
                if (is_natural) begin
                    next_state = DONE;
                end else if (pscore <= 4'd5) begin
                    next_state = DP3;
                end else if (dscore <= 4'd5) begin
                    next_state = DD3;
                end else begin
                    next_state = DONE;
                end
            end
            DP3:   next_state = EVAL2;
            EVAL2: next_state = banker_draws ? DD3 : DONE;
            DD3:   next_state = DONE;
            DONE:  next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // State register; reset is sampled on the same edge that loads cards.
    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Moore outputs; only the lights also look at the live scores in DONE.
    always_comb begin
        load_pcard1      = 1'b0;
        load_pcard2      = 1'b0;
        load_pcard3      = 1'b0;
        load_dcard1      = 1'b0;
        load_dcard2      = 1'b0;
        load_dcard3      = 1'b0;
        player_win_light = 1'b0;
        dealer_win_light = 1'b0;
        round_done       = 1'b0;
        case (state)
            DP1: load_pcard1 = 1'b1;
            DD1: load_dcard1 = 1'b1;
            DP2: load_pcard2 = 1'b1;
            DD2: load_dcard2 = 1'b1;
            DP3: load_pcard3 = 1'b1;
            DD3: load_dcard3 = 1'b1;
            DONE: begin
                round_done       = 1'b1;
                player_win_light = (pscore >= dscore);
                dealer_win_light = (dscore >= pscore);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_baccarat_ctrl.sv
// Testbench for baccarat_ctrl.
// A driver plays whole rounds and queues the expected deal for each one; an
// independent monitor records the strobes every cycle and checks them when
// the round reports done.
module tb_baccarat_ctrl;

    logic       slow_clock = 1'b0;
    logic       resetb     = 1'b0;
    logic [3:0] pscore     = 4'd0;
    logic [3:0] dscore     = 4'd0;
    logic [3:0] pcard3     = 4'd0;
    logic       load_pcard1;
    logic       load_pcard2;
    logic       load_pcard3;
    logic       load_dcard1;
    logic       load_dcard2;
    logic       load_dcard3;
    logic       player_win_light;
    logic       dealer_win_light;
    logic       round_done;

    localparam logic [5:0] S_P1 = 6'b100000;
    localparam logic [5:0] S_D1 = 6'b010000;
    localparam logic [5:0] S_P2 = 6'b001000;
    localparam logic [5:0] S_D2 = 6'b000100;
    localparam logic [5:0] S_P3 = 6'b000010;
    localparam logic [5:0] S_D3 = 6'b000001;

    typedef struct packed {
        logic [3:0]  len;
        logic [71:0] trace;
        logic        pl;
        logic        dl;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    baccarat_ctrl dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .round_done       (round_done)
    );

    // Free-running key-press clock.
    always #5 slow_clock = ~slow_clock;

    // Reference round: which hands draw, the resulting deal sequence, the lights.
    function automatic exp_t model(input int p, input int d, input int c3);
        exp_t       e;
        logic [5:0] steps[$];
        int         p3v;
        bit         nat, pdraw, bdraw;
        nat   = (p >= 8) || (d >= 8);
        pdraw = !nat && (p <= 5);
        p3v   = (c3 >= 1 && c3 <= 9) ? c3 : 0;
        if (nat) begin
            bdraw = 1'b0;
        end else if (!pdraw) begin
            bdraw = (d <= 5);
        end else begin
            case (d)
                0, 1, 2: bdraw = 1'b1;
                3:       bdraw = (p3v != 8);
                4:       bdraw = (p3v >= 2) && (p3v <= 7);
                5:       bdraw = (p3v >= 4) && (p3v <= 7);
                6:       bdraw = (p3v >= 6) && (p3v <= 7);
                default: bdraw = 1'b0;
            endcase
        end
        steps.push_back(S_P1);
        steps.push_back(S_D1);
        steps.push_back(S_P2);
        steps.push_back(S_D2);
        steps.push_back(6'b0);
        if (pdraw) begin
            steps.push_back(S_P3);
            steps.push_back(6'b0);
        end
        if (bdraw) begin
            steps.push_back(S_D3);
        end
        e.trace = '0;
        foreach (steps[i]) begin
            e.trace[i*6 +: 6] = steps[i];
        end
        e.len = 4'(steps.size() + 1);
        e.pl  = (p >= d);
        e.dl  = (d >= p);
        return e;
    endfunction

    // One comparison: counts it, and reports it when the values differ.
    task automatic checkOutput(input string name, input logic [71:0] actual,
                               input logic [71:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, required, $time);
        end
    endtask

    // Play one full round from reset, change the player score while in DONE,
    // then reset out of DONE.
    task automatic applyStimulus(input int p, input int d, input int c3, input int post_p);
        exp_t e;
        e = model(p, d, c3);
        sb_q.push_back(e);
        pscore = 4'(p);
        dscore = 4'(d);
        pcard3 = 4'd0;
        @(negedge slow_clock);
        resetb = 1'b1;
        for (int k = 1; k <= int'(e.len) + 1; k++) begin
            @(negedge slow_clock);
            if (k == 6) pcard3 = 4'(c3);
            if (k == int'(e.len)) pscore = 4'(post_p);
        end
        resetb = 1'b0;
        @(negedge slow_clock);
    endtask

    // Start a round and pull reset while the second player card is strobing.
    task automatic midReset(input int p, input int d);
        pscore = 4'(p);
        dscore = 4'(d);
        pcard3 = 4'd0;
        @(negedge slow_clock);
        resetb = 1'b1;
        repeat (3) @(negedge slow_clock);
        resetb = 1'b0;
        @(negedge slow_clock);
    endtask

    // Monitor: records strobes each cycle and scores the round when done rises.
    initial begin : monitor
        logic        rst_at_edge;
        logic [71:0] obs;
        logic [5:0]  word;
        int          obs_n;
        bit          done_seen;
        exp_t        cur;
        obs       = '0;
        obs_n     = 0;
        done_seen = 1'b0;
        forever begin
            @(posedge slow_clock);
            rst_at_edge = resetb;
            #1;
            word = {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3};
            if (!rst_at_edge) begin
                checkOutput("reset_outputs",
                            72'({word, round_done, player_win_light, dealer_win_light}), 72'(0));
                obs       = '0;
                obs_n     = 0;
                done_seen = 1'b0;
            end else if (done_seen) begin
                checkOutput("done_hold", 72'(round_done), 72'(1));
                checkOutput("done_lights", 72'({player_win_light, dealer_win_light}),
                            72'({pscore >= dscore, dscore >= pscore}));
            end else if (round_done) begin
                done_seen = 1'b1;
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_done: got round_done=1, expected no round pending");
                end else begin
                    cur = sb_q.pop_front();
                    checkOutput("round_len", 72'(obs_n + 1), 72'(cur.len));
                    checkOutput("strobe_trace", obs, cur.trace);
                    checkOutput("win_lights", 72'({player_win_light, dealer_win_light}),
                                72'({cur.pl, cur.dl}));
                end
            end else begin
                checkOutput("strobe_onehot", 72'($countones(word) <= 1), 72'(1));
                if (obs_n >= 11) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL round_timeout: got %0d edges without done, expected at most 9", obs_n + 1);
                    done_seen = 1'b1;
                    if (sb_q.size() > 0) void'(sb_q.pop_front());
                end else begin
                    obs[obs_n*6 +: 6] = word;
                    obs_n++;
                end
            end
        end
    end

    // Driver: directed rounds from the interesting corners, then random ones.
    initial begin : driver
        int sweep[5];
        sweep = '{6, 7, 5, 8, 11};
        repeat (3) @(negedge slow_clock);

        $display("[TB] directed rounds");
        applyStimulus(8, 3, 0, 8);
        applyStimulus(7, 6, 0, 7);
        applyStimulus(4, 6, 12, 6);
        applyStimulus(2, 3, 8, 2);
        applyStimulus(2, 3, 9, 2);
        foreach (sweep[i]) applyStimulus(3, 6, sweep[i], 3);
        applyStimulus(6, 5, 0, 6);
        applyStimulus(9, 9, 4, 1);
        applyStimulus(0, 0, 1, 0);

        $display("[TB] reset mid-deal");
        midReset(5, 2);
        applyStimulus(5, 2, 3, 1);

        $display("[TB] random rounds");
        for (int r = 0; r < 60; r++) begin
            applyStimulus(int'($urandom_range(9)), int'($urandom_range(9)),
                          int'($urandom_range(13, 1)), int'($urandom_range(9)));
        end

        repeat (3) @(negedge slow_clock);
        checkOutput("scoreboard_drained", 72'(sb_q.size()), 72'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
